// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared constants for the serial character receiver: FSM state encodings,
// default bit period and 8N1 frame constants.
// -----------------------------------------------------------------------------
package serial_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 16;
    localparam int unsigned DATA_BITS        = 8;
    localparam logic        STOP_LEVEL       = 1'b1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

endpackage

// File: rtl/serial_char_rx_if.sv
// -----------------------------------------------------------------------------
// serial_char_rx_if
// Serial line and character bus of the receiver.
//   rxd         : asynchronous serial line, idle high
//   ascii       : last good character, held
//   ascii_valid : one-cycle strobe, ascii just updated
//   frame_err   : one-cycle strobe, stop bit sampled low
//   busy        : receiver not idle
// master = receiver side, slave = line driver / character consumer.
// -----------------------------------------------------------------------------
interface serial_char_rx_if;
    import serial_pkg::*;

    logic                 rxd;
    logic [DATA_BITS-1:0] ascii;
    logic                 ascii_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rxd,
        output ascii,
        output ascii_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rxd,
        input  ascii,
        input  ascii_valid,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/serial_char_rx_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Generic two-flop synchroniser for an asynchronous single-bit input.
//   clk       : destination clock
//   rst       : synchronous active-low reset, flops load RESET_VAL
//   i_d       : asynchronous input
//   o_q       : synchronised output (2-cycle latency)
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/serial_char_rx.sv
// -----------------------------------------------------------------------------
// serial_char_rx
// 8N1 serial receiver feeding the keyword detector. Good frames update the
// held ascii byte with a one-cycle ascii_valid strobe; a low stop bit gives a
// one-cycle frame_err strobe and the line must return high before the next
// frame is accepted.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : serial_char_rx_if.master (rxd in; ascii, ascii_valid, frame_err,
//          busy out)
// -----------------------------------------------------------------------------
module serial_char_rx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    serial_char_rx_if.master bus
);

    localparam int unsigned          CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic                 w_rxd_s;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_ascii;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_stop_hit;
    logic                 r_stop_bit;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.rxd),
        .o_q (w_rxd_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_ascii    <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop_hit <= 1'b0;
            r_stop_bit <= 1'b1;
        end else begin
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop_hit <= 1'b0;

            // Outputs are registered one edge after the stop sample, so the
            // FSM is already back in IDLE (or BREAK) when the strobe appears.
            if (r_stop_hit) begin
                if (r_stop_bit == STOP_LEVEL) begin
                    r_ascii <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ferr  <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxd_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        if (!w_rxd_s) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_shift[r_idx] <= w_rxd_s;
                        r_cnt          <= '0;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_stop_hit <= 1'b1;
                        r_stop_bit <= w_rxd_s;
                        r_cnt      <= '0;
                        r_state    <= (w_rxd_s == STOP_LEVEL) ? S_IDLE : S_BREAK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A held-low line yields a single frame_err, not a stream
                    // of zero-byte frames.
                    if (w_rxd_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ascii       = r_ascii;
    assign bus.ascii_valid = r_valid;
    assign bus.frame_err   = r_ferr;
    assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_char_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_char_rx
// Frames are driven bit by bit; each frame pushes its expected strobe (kind,
// byte, cycle) to a queue, and a negedge monitor pops and compares whenever
// the receiver strobes.
// -----------------------------------------------------------------------------
module tb_serial_char_rx;
    import serial_pkg::*;

    localparam int unsigned CPB = 16;
    // rxd driven just after edge P: synchroniser puts it on rxd_s at P+2,
    // FSM sees it at E=P+3, strobe registered at E + CPB/2 + 9*CPB + 1.
    localparam int unsigned LAT = 3 + CPB / 2 + 9 * CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_char_rx_if u_if ();

    serial_char_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        is_err;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned gap;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [7:0]  last_good = 8'h00;
    logic [31:0] det = '0;
    logic        alert = 1'b0;

    // Strobe monitor / scoreboard consumer
    always @(negedge clk) begin
        if (rst && (u_if.ascii_valid || u_if.frame_err)) begin
            check("strobe_exclusive", 32'(u_if.ascii_valid & u_if.frame_err), 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_strobe", {30'd0, u_if.frame_err, u_if.ascii_valid}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("strobe_kind", 32'(u_if.frame_err), 32'(mon_e.is_err));
                check("strobe_cycle", cyc, mon_e.cyc);
                if (mon_e.is_err) begin
                    check("ascii_held_on_ferr", 32'(u_if.ascii), 32'(last_good));
                end else begin
                    check("ascii_data", 32'(u_if.ascii), 32'(mon_e.data));
                    last_good = mon_e.data;
                    det = {det[23:0], u_if.ascii};
                    if (det == "BOMB") alert = 1'b1;
                end
            end
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        u_if.rxd = b;
        cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.is_err = (stop != STOP_LEVEL);
        e.data   = d;
        e.cyc    = cyc + LAT;
        sbq.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (sbq.size() != 0 && n < budget) begin
            cycles(1);
            n++;
        end
        check("drain_pending", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ascii"}, 32'(u_if.ascii), 32'h00);
        check({tag, "_valid"}, 32'(u_if.ascii_valid), 32'd0);
        check({tag, "_ferr"},  32'(u_if.frame_err), 32'd0);
        check({tag, "_busy"},  32'(u_if.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [7:0]  o_char;

        vecs[0] = '{8'h42, 1'b1, 20};
        vecs[1] = '{8'h42, 1'b1, 0};
        vecs[2] = '{8'h4F, 1'b1, 0};
        vecs[3] = '{8'h4D, 1'b1, 0};
        vecs[4] = '{8'h42, 1'b1, 40};

        // Reset and idle
        rst = 1'b0;
        u_if.rxd = 1'b1;
        cycles(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        cycles(500);
        check_reset_outputs("idle");

        // Good frame then back-to-back "BOMB"
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            u_if.rxd = 1'b1;
            if (vecs[i].gap != 0) cycles(vecs[i].gap);
        end
        drain(400);
        check("detector_alert", 32'(alert), 32'd1);
        check("ascii_after_bomb", 32'(u_if.ascii), 32'h42);

        // Glitch rejection
        u_if.rxd = 1'b0;
        cycles(4);
        check("glitch_busy", 32'(u_if.busy), 32'd1);
        u_if.rxd = 1'b1;
        cycles(20);
        check("glitch_idle", 32'(u_if.busy), 32'd0);
        check("glitch_ascii", 32'(u_if.ascii), 32'h42);

        // Framing error followed by break, then a good 'A'
        send_frame(8'h4D, 1'b0);
        cycles(5 * CPB);
        check("break_busy", 32'(u_if.busy), 32'd1);
        check("break_ascii", 32'(u_if.ascii), 32'h42);
        u_if.rxd = 1'b1;
        cycles(4);
        check("break_release", 32'(u_if.busy), 32'd0);
        send_frame(8'h41, 1'b1);
        drain(300);

        // Reset during data bit 4 of 'O'
        o_char = 8'h4F;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(o_char[i]);
        u_if.rxd = o_char[4];
        cycles(CPB / 2);
        check("midframe_busy", 32'(u_if.busy), 32'd1);
        rst = 1'b0;
        last_good = 8'h00;
        cycles(1);
        check_reset_outputs("midreset");
        cycles(1);
        rst = 1'b1;
        u_if.rxd = 1'b1;
        cycles(6 * CPB);
        check_reset_outputs("after_reset");
        send_frame(8'h42, 1'b1);
        drain(300);
        check("final_ascii", 32'(u_if.ascii), 32'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_char_rx.md
# serial_char_rx

- Upstream feeder for the keyword-detection stage.
- Deserialises an asynchronous 8N1 serial line (idle high, start bit low, 8 data bits LSB first, stop bit high) into 8-bit ASCII characters.
- Presents each character on a held byte bus with a one-cycle valid strobe.
- Flags malformed frames so the detector downstream never sees a corrupted character.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit. Even, minimum 4.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset. rst=0 at a rising edge resets the block.
- rxd  in  1  asynchronous serial line, idle high.
- ascii  out  8  last good character, held until the next good frame.
- ascii_valid  out  1  one-cycle strobe: ascii has just been updated.
- frame_err  out  1  one-cycle strobe: the stop bit sampled low.
- busy  out  1  high whenever state is not IDLE.

## Operation
- rxd passes through a 2-flop synchroniser (rxd_s). All decisions use rxd_s.
- Reset values: ascii=8'h00, ascii_valid=0, frame_err=0, busy=0, state=IDLE, counters cleared, synchroniser flops=1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rxd_s=0 → START, bit counter cnt=0.
- START:
  - cnt counts up each cycle.
  - At cnt=CLKS_PER_BIT/2-1, sample rxd_s.
  - Sample 0 → DATA, cnt=0, bit index idx=0.
  - Sample 1 → glitch; return to IDLE with no strobe.
- DATA:
  - At cnt=CLKS_PER_BIT-1, shift rxd_s into bit idx of the shift register, cnt=0, idx++.
  - After idx=7 is sampled → STOP.
- STOP:
  - At cnt=CLKS_PER_BIT-1, sample rxd_s.
  - Sample 1 → load ascii from the shift register, pulse ascii_valid, → IDLE.
  - Sample 0 → pulse frame_err, ascii unchanged, → BREAK.
- BREAK: wait for rxd_s=1, then → IDLE. A held-low line (break) produces exactly one frame_err, never repeated frames.
- ascii_valid and frame_err are never high in the same cycle.
- Each strobe is high for exactly one cycle.
- Reset mid-frame: abort immediately, outputs return to reset values, partial byte discarded, no strobe.
- A new start bit is accepted in the cycle IDLE is re-entered. No extra idle time is required after a good stop bit.

## Timing
- Synchroniser latency: 2 cycles from an rxd transition to rxd_s.
- Let edge E be the first rising edge at which rxd_s=0 in IDLE.
- Event schedule relative to E:
  - START sample at E + CLKS_PER_BIT/2.
  - Data bit k sampled at E + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop sampled at E + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
  - ascii/ascii_valid (or frame_err) registered at the edge after the stop sample: E + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1.
- Worked example, CLKS_PER_BIT=16: strobe 153 cycles after E.
- No back-pressure. The downstream stage must accept one character per frame, i.e. at most one strobe per 10·CLKS_PER_BIT cycles.
- Widths:
  - cnt is $clog2(CLKS_PER_BIT) bits and never wraps past CLKS_PER_BIT-1.
  - idx is 3 bits; overflow from 7 is the DATA→STOP condition.

## Structure
- Shared package `serial_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK) as a 3-bit localparam set.
  - default CLKS_PER_BIT.
  - frame constants: DATA_BITS=8, STOP_LEVEL=1.
- One natural sub-module, `sync2`: the generic 2-flop synchroniser with reset value parameter. It is reused for other asynchronous inputs.
- Everything else (FSM, counters, shift register, output registers) lives in serial_char_rx.

## Test plan
- Reset and idle:
  - Hold rst=0 for 3 cycles with rxd=1, then release.
  - Required: ascii=8'h00; ascii_valid, frame_err and busy all 0; no strobe for 500 idle cycles.
- Good frame, CLKS_PER_BIT=16:
  - Send 'B' (8'h42).
  - Required: ascii=8'h42 and ascii_valid=1 for exactly one cycle, 153 cycles after E.
- Back-to-back string:
  - Send "BOMB" with no idle gap between frames.
  - Required: four strobes carrying 42, 4F, 4D, 42, spaced exactly 160 cycles apart.
  - Feed the output to the detector and check its alert.
- Glitch rejection:
  - Drive rxd low for 4 cycles, then high.
  - Required: return to IDLE; no ascii_valid, no frame_err; ascii unchanged.
- Framing error and break:
  - Send 'M' with stop bit 0, then hold rxd low for 5 bit times.
  - Required: one frame_err pulse, ascii keeps the previous value, busy stays high until rxd returns high, then a following 'A' (8'h41) is received correctly.
- Reset mid-frame:
  - Assert rst=0 during data bit 4 of 'O'.
  - Required: outputs return to reset values, no strobe for that frame, next frame 'B' received correctly.
